// File: rtl/board_arbiter_if.sv
// ---------------------------------------------------------------------------
// board_arbiter_if
//
// Purpose:
//   Groups the move/clear handshake, the display read port and the status
//   outputs of the board arbiter into one bundle. The arbiter connects through
//   the slave modport; whatever drives moves and reads the board (game
//   controller, display scanner, testbench) uses the master modport.
//
// Signals:
//   vblank      display vertical blanking; board writes only happen while high
//   mv_valid    move request valid
//   mv_ready    arbiter is idle and can accept a move or clear
//   mv_col      target column of the move (3 bits)
//   mv_player   piece owner, 0 = red, 1 = yellow
//   clr_req     request to empty the whole board
//   mv_done     one-cycle pulse when a move or clear completes
//   mv_status   00 ok, 01 column full, 10 bad column
//   mv_row      landing row of the last successful move
//   rd_col      display read column
//   rd_row      display read row
//   rd_cell     registered cell contents: 00 empty, 01 red, 10 yellow
//   board_full  every column holds a full stack of pieces
// ---------------------------------------------------------------------------
interface board_arbiter_if;
  logic       vblank;
  logic       mv_valid;
  logic       mv_ready;
  logic [2:0] mv_col;
  logic       mv_player;
  logic       clr_req;
  logic       mv_done;
  logic [1:0] mv_status;
  logic [2:0] mv_row;
  logic [2:0] rd_col;
  logic [2:0] rd_row;
  logic [1:0] rd_cell;
  logic       board_full;

  // Arbiter side
  modport slave (
    input  vblank, mv_valid, mv_col, mv_player, clr_req, rd_col, rd_row,
    output mv_ready, mv_done, mv_status, mv_row, rd_cell, board_full
  );

  // Controller / display side
  modport master (
    output vblank, mv_valid, mv_col, mv_player, clr_req, rd_col, rd_row,
    input  mv_ready, mv_done, mv_status, mv_row, rd_cell, board_full
  );
endinterface

// File: rtl/board_arbiter.sv
// ---------------------------------------------------------------------------
// board_arbiter
//
// Purpose:
//   Owns a COLS x ROWS drop-piece game board (row 0 is the bottom row) and
//   serialises updates to it. A move drops a piece into the lowest free row
//   of a column; a clear empties the board. The board is only ever written
//   during display vertical blanking so the display never sees a half-updated
//   frame. The display reads cells through a registered read port.
//
// Parameters:
//   COLS  number of board columns (default 7)
//   ROWS  number of board rows    (default 6)
//
// Ports:
//   clk    system clock, all state changes on its rising edge
//   rst_n  asynchronous active-low reset
//   bus    board_arbiter_if.slave: move/clear handshake, status, read port
// ---------------------------------------------------------------------------
module board_arbiter #(
  parameter int COLS = 7,
  parameter int ROWS = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  board_arbiter_if.slave  bus
);

  // Height counters must reach ROWS itself, so they need one extra value.
  localparam int HW = $clog2(ROWS + 1);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    WAIT_VBL,
    COMMIT,
    CLEAR,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    col_q, col_d;
  logic          player_q, player_d;
  logic [1:0]    status_q, status_d;
  logic [2:0]    row_q, row_d;
  logic          done_q;
  logic [1:0]    rd_cell_q;
  logic          full;

  logic [1:0]    cells_q   [COLS][ROWS];
  logic [HW-1:0] heights_q [COLS];

  logic          col_ok;
  logic [HW-1:0] cur_height;
  logic          do_write;
  logic          do_clear;
  logic          rd_ok;

  // The latched column may be out of range (the request port is wider than
  // the board), so the height lookup is guarded and yields zero for a bad
  // column; CHECK rejects that column before the height is ever used.
  always_comb begin
    col_ok     = 32'(col_q) < COLS;
    cur_height = '0;
    if (col_ok) begin
      cur_height = heights_q[col_q];
    end
  end

  // Next-state and control decode. Only IDLE accepts requests; a clear wins
  // over a simultaneous move, which is then simply not taken. Writes and
  // clears are gated on vblank in the very cycle they take effect, so if
  // vblank drops exactly in the COMMIT cycle the move goes back to waiting
  // rather than touching the board outside blanking.
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    player_d = player_q;
    status_d = status_q;
    row_d    = row_q;
    do_write = 1'b0;
    do_clear = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.clr_req) begin
          state_d = CLEAR;
        end else if (bus.mv_valid) begin
          col_d    = bus.mv_col;
          player_d = bus.mv_player;
          state_d  = CHECK;
        end
      end

      CHECK: begin
        if (!col_ok) begin
          status_d = 2'b10;
          state_d  = DONE;
        end else if (32'(cur_height) == ROWS) begin
          status_d = 2'b01;
          state_d  = DONE;
        end else begin
          state_d = WAIT_VBL;
        end
      end

      WAIT_VBL: begin
        if (bus.vblank) begin
          state_d = COMMIT;
        end
      end

      COMMIT: begin
        if (bus.vblank) begin
          do_write = 1'b1;
          row_d    = 3'(cur_height);
          status_d = 2'b00;
          state_d  = DONE;
        end else begin
          state_d = WAIT_VBL;
        end
      end

      CLEAR: begin
        if (bus.vblank) begin
          do_clear = 1'b1;
          status_d = 2'b00;
          state_d  = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and status registers. mv_done is registered from the next state
  // so it is high for exactly the one cycle spent in DONE; status and row
  // hold their values between completions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      col_q    <= '0;
      player_q <= 1'b0;
      status_q <= 2'b00;
      row_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      player_q <= player_d;
      status_q <= status_d;
      row_q    <= row_d;
      done_q   <= (state_d == DONE);
    end
  end

  // Board storage: cell array plus one stack height per column. A commit
  // drops the piece onto the current top of the column and bumps its height;
  // a clear empties everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < COLS; c++) begin
        heights_q[c] <= '0;
        for (int r = 0; r < ROWS; r++) begin
          cells_q[c][r] <= 2'b00;
        end
      end
    end else if (do_clear) begin
      for (int c = 0; c < COLS; c++) begin
        heights_q[c] <= '0;
        for (int r = 0; r < ROWS; r++) begin
          cells_q[c][r] <= 2'b00;
        end
      end
    end else if (do_write) begin
      cells_q[col_q][cur_height] <= player_q ? 2'b10 : 2'b01;
      heights_q[col_q]           <= heights_q[col_q] + 1'b1;
    end
  end

  // Display read port. Addresses off the board read as empty. Because the
  // array is sampled with the pre-edge contents, a read of a cell being
  // written in the same cycle returns the old value.
  always_comb begin
    rd_ok = (32'(bus.rd_col) < COLS) && (32'(bus.rd_row) < ROWS);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cell_q <= 2'b00;
    end else if (rd_ok) begin
      rd_cell_q <= cells_q[bus.rd_col][bus.rd_row];
    end else begin
      rd_cell_q <= 2'b00;
    end
  end

  // The board is full when every column's stack has reached the top.
  always_comb begin
    full = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      if (32'(heights_q[c]) != ROWS) begin
        full = 1'b0;
      end
    end
  end

  assign bus.mv_ready   = (state_q == IDLE);
  assign bus.mv_done    = done_q;
  assign bus.mv_status  = status_q;
  assign bus.mv_row     = row_q;
  assign bus.rd_cell    = rd_cell_q;
  assign bus.board_full = full;

endmodule

// File: tb/tb_board_arbiter.sv
// ---------------------------------------------------------------------------
// tb_board_arbiter
//
// Self-checking bench for board_arbiter: a table of directed moves, hand
// sequences for the blanking, clear and reset-abort corners, and a random
// run checked against a plain array model of the board.
// ---------------------------------------------------------------------------
module tb_board_arbiter;

  logic clk;
  logic rst_n;

  board_arbiter_if bus();

  board_arbiter #(.COLS(7), .ROWS(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;

  // Reference board: model[c][r] holds 0 empty, 1 red, 2 yellow.
  int model [7][6];
  int mStatus;
  int mRow;

  typedef struct {
    int col;
    bit player;
    int expStatus;
    int expRow;
    int expLat;
  } vec_t;

  vec_t vecs [11];

  // Count every comparison; report a mismatch on one line.
  task automatic checkOutput(input string name, input int actual, input int expected);
    nChecks++;
    if (actual != expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic int colHeight(input int c);
    int h = 0;
    for (int r = 0; r < 6; r++) if (model[c][r] != 0) h++;
    return h;
  endfunction

  function automatic int modelFull();
    for (int c = 0; c < 7; c++) if (colHeight(c) != 6) return 0;
    return 1;
  endfunction

  task automatic modelMove(input int col, input bit player);
    int h;
    if (col >= 7) begin
      mStatus = 2;
    end else begin
      h = colHeight(col);
      if (h == 6) begin
        mStatus = 1;
      end else begin
        model[col][h] = player ? 2 : 1;
        mRow = h;
        mStatus = 0;
      end
    end
  endtask

  task automatic modelClear();
    for (int c = 0; c < 7; c++)
      for (int r = 0; r < 6; r++) model[c][r] = 0;
    mStatus = 0;
  endtask

  task automatic modelReset();
    modelClear();
    mRow = 0;
  endtask

  // Present one request in an IDLE cycle and let the acceptance edge pass.
  task automatic applyStimulus(input int col, input bit player, input bit mv, input bit clr);
    logic [31:0] colBits;
    colBits = col;
    checkOutput("ready_before_req", bus.mv_ready, 1);
    bus.mv_col    = colBits[2:0];
    bus.mv_player = player;
    bus.mv_valid  = mv;
    bus.clr_req   = clr;
    tick();
    bus.mv_valid = 1'b0;
    bus.clr_req  = 1'b0;
    checkOutput("ready_low_after_accept", bus.mv_ready, 0);
  endtask

  // Wait (bounded) for mv_done; n = cycles waited. Then confirm the pulse is
  // one cycle wide and the arbiter is ready again.
  task automatic waitDone(input bit randVbl, output int n);
    n = 0;
    while (bus.mv_done !== 1'b1 && n < 300) begin
      if (randVbl) bus.vblank = 1'($urandom % 2);
      tick();
      n++;
    end
    checkOutput("done_seen", int'(bus.mv_done === 1'b1), 1);
    tick();
    checkOutput("done_one_cycle", bus.mv_done, 0);
    checkOutput("ready_after_done", bus.mv_ready, 1);
  endtask

  task automatic readCell(input int c, input int r, output int v);
    logic [31:0] cb, rb;
    cb = c;
    rb = r;
    bus.rd_col = cb[2:0];
    bus.rd_row = rb[2:0];
    tick();
    v = bus.rd_cell;
  endtask

  task automatic scanBoard(input string name);
    int v;
    for (int c = 0; c < 7; c++)
      for (int r = 0; r < 6; r++) begin
        readCell(c, r, v);
        checkOutput(name, v, model[c][r]);
      end
  endtask

  // Global time limit so the run always ends.
  initial begin
    #900000;
    $display("[TB] FAIL watchdog: time limit reached, simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int v;
    int p;
    int col;
    int r;

    vecs[0]  = '{3, 1'b0, 0, 0, 4};
    for (int i = 0; i < 6; i++) vecs[1+i] = '{2, 1'b1, 0, i, 4};
    vecs[7]  = '{2, 1'b1, 1, 5, 2};
    vecs[8]  = '{7, 1'b0, 2, 5, 2};
    vecs[9]  = '{5, 1'b1, 0, 0, 4};
    vecs[10] = '{2, 1'b0, 1, 0, 2};

    bus.vblank    = 1'b0;
    bus.mv_valid  = 1'b0;
    bus.mv_col    = 3'd0;
    bus.mv_player = 1'b0;
    bus.clr_req   = 1'b0;
    bus.rd_col    = 3'd0;
    bus.rd_row    = 3'd0;
    rst_n         = 1'b0;

    // ---- Reset state ----
    doReset();
    modelReset();
    checkOutput("reset_ready", bus.mv_ready, 1);
    checkOutput("reset_done", bus.mv_done, 0);
    checkOutput("reset_status", bus.mv_status, 0);
    checkOutput("reset_row", bus.mv_row, 0);
    checkOutput("reset_rd_cell", bus.rd_cell, 0);
    checkOutput("reset_full", bus.board_full, 0);

    // ---- Directed move table, vblank held high ----
    bus.vblank = 1'b1;
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].col, vecs[i].player, 1'b1, 1'b0);
      waitDone(1'b0, n);
      modelMove(vecs[i].col, vecs[i].player);
      checkOutput("vec_latency", n + 1, vecs[i].expLat);
      checkOutput("vec_status", bus.mv_status, vecs[i].expStatus);
      checkOutput("vec_row", bus.mv_row, vecs[i].expRow);
      if (i == 0) begin
        readCell(3, 0, v);
        checkOutput("first_move_cell", v, 1);
      end
    end
    readCell(7, 0, v);
    checkOutput("rd_col_out_of_range", v, 0);
    readCell(2, 6, v);
    checkOutput("rd_row_out_of_range", v, 0);
    readCell(2, 5, v);
    checkOutput("top_of_full_column", v, 2);
    scanBoard("table_board");

    // ---- Move held off by blanking for 100 cycles ----
    bus.vblank = 1'b0;
    bus.rd_col = 3'd0;
    bus.rd_row = 3'd0;
    applyStimulus(0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 100; i++) begin
      tick();
      checkOutput("vbl_wait_ready", bus.mv_ready, 0);
      checkOutput("vbl_wait_done", bus.mv_done, 0);
      checkOutput("vbl_wait_cell", bus.rd_cell, 0);
    end
    bus.vblank = 1'b1;
    waitDone(1'b0, n);
    modelMove(0, 1'b1);
    checkOutput("vbl_commit_latency", n, 2);
    checkOutput("vbl_commit_cell", bus.rd_cell, 2);
    checkOutput("vbl_commit_row", bus.mv_row, 0);

    // ---- Clear beats a simultaneous move ----
    bus.vblank = 1'b0;
    applyStimulus(4, 1'b0, 1'b1, 1'b1);
    tick();
    tick();
    readCell(2, 0, v);
    checkOutput("clear_waits_for_vblank", v, 2);
    bus.vblank = 1'b1;
    waitDone(1'b0, n);
    modelClear();
    checkOutput("clear_latency", n, 1);
    checkOutput("clear_status", bus.mv_status, 0);
    checkOutput("clear_full", bus.board_full, 0);
    scanBoard("clear_board");

    // ---- Fill the board, then abort a clear and a move with reset ----
    doReset();
    modelReset();
    bus.vblank = 1'b1;
    for (int c = 0; c < 7; c++)
      for (int rr = 0; rr < 6; rr++) begin
        p = $urandom % 2;
        applyStimulus(c, p[0], 1'b1, 1'b0);
        waitDone(1'b0, n);
        modelMove(c, p[0]);
        checkOutput("fill_status", bus.mv_status, mStatus);
        checkOutput("fill_full", bus.board_full, modelFull());
      end
    checkOutput("board_full_set", bus.board_full, 1);
    scanBoard("fill_board");
    applyStimulus(6, 1'b0, 1'b1, 1'b0);
    waitDone(1'b0, n);
    modelMove(6, 1'b0);
    checkOutput("full_col_latency", n + 1, 2);
    checkOutput("full_col_status", bus.mv_status, 1);

    bus.vblank = 1'b0;
    applyStimulus(0, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    checkOutput("clear_pending_full", bus.board_full, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    modelReset();
    checkOutput("abort_clear_ready", bus.mv_ready, 1);
    checkOutput("abort_clear_full", bus.board_full, 0);
    checkOutput("abort_clear_row", bus.mv_row, 0);
    checkOutput("abort_clear_status", bus.mv_status, 0);
    scanBoard("abort_clear_board");

    applyStimulus(3, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("abort_move_ready", bus.mv_ready, 1);
    bus.vblank = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("abort_move_no_done", bus.mv_done, 0);
    end
    readCell(3, 0, v);
    checkOutput("abort_move_no_write", v, 0);
    checkOutput("abort_move_full", bus.board_full, 0);

    // ---- Random traffic against the array model ----
    doReset();
    modelReset();
    for (int t = 0; t < 150; t++) begin
      r   = $urandom % 20;
      col = $urandom_range(0, 7);
      p   = $urandom % 2;
      bus.vblank = 1'($urandom % 2);
      if (r == 0) begin
        applyStimulus(0, 1'b0, 1'b0, 1'b1);
        waitDone(1'b1, n);
        modelClear();
      end else if (r == 1) begin
        applyStimulus(col, p[0], 1'b1, 1'b1);
        waitDone(1'b1, n);
        modelClear();
      end else begin
        applyStimulus(col, p[0], 1'b1, 1'b0);
        waitDone(1'b1, n);
        modelMove(col, p[0]);
        if (mStatus != 0) checkOutput("rand_reject_latency", n + 1, 2);
      end
      checkOutput("rand_status", bus.mv_status, mStatus);
      checkOutput("rand_row", bus.mv_row, mRow);
      checkOutput("rand_full", bus.board_full, modelFull());
      if (t % 30 == 29) scanBoard("rand_board");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/board_arbiter.md
BOARD_ARBITER -- requirements
Module: board_arbiter

Interface
REQ-001 SHALL have parameter COLS, default 7, meaning number of board columns.
REQ-002 SHALL have parameter ROWS, default 6, meaning number of board rows; row 0 is the bottom row.
REQ-003 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port vblank  input  1  high while the display is in vertical blanking.
REQ-006 SHALL have port mv_valid  input  1  move request valid.
REQ-007 SHALL have port mv_ready  output  1  high when a move or clear can be accepted.
REQ-008 SHALL have port mv_col  input  3  target column of the move.
REQ-009 SHALL have port mv_player  input  1  piece owner: 0 = red, 1 = yellow.
REQ-010 SHALL have port clr_req  input  1  request to empty the whole board.
REQ-011 SHALL have port mv_done  output  1  one-cycle pulse when a move or clear completes.
REQ-012 SHALL have port mv_status  output  2  result: 00 ok, 01 column full, 10 bad column.
REQ-013 SHALL have port mv_row  output  3  landing row of the last successful move.
REQ-014 SHALL have port rd_col  input  3  display read column.
REQ-015 SHALL have port rd_row  input  3  display read row.
REQ-016 SHALL have port rd_cell  output  2  cell contents: 00 empty, 01 red, 10 yellow.
REQ-017 SHALL have port board_full  output  1  high when every column holds ROWS pieces.

Function
REQ-018 SHALL hold a COLS x ROWS array of 2-bit cells and one height counter per column (0..ROWS).
REQ-019 SHALL implement FSM states IDLE, CHECK, WAIT_VBL, COMMIT, CLEAR, DONE.
REQ-020 SHALL drive mv_ready high only in IDLE.
REQ-021 IDLE: clr_req high -> CLEAR; else mv_valid high -> latch mv_col and mv_player, then go to CHECK.
REQ-022 SHALL give clr_req priority over mv_valid when both are high in the same IDLE cycle; the move is not accepted.
REQ-023 CHECK: latched col >= COLS -> status 10, go to DONE; height == ROWS -> status 01, go to DONE; otherwise go to WAIT_VBL.
REQ-024 WAIT_VBL: stay until vblank is high, then go to COMMIT.
REQ-025 COMMIT (one cycle): write (player ? 10 : 01) to cell[col][height]; set mv_row to height; increment height; set status 00; go to DONE.
REQ-026 CLEAR: wait for vblank high; in that cycle zero all cells and heights, set status 00, go to DONE.
REQ-027 DONE: assert mv_done for exactly one cycle, then return to IDLE.
REQ-028 SHALL never modify the cell array outside a cycle in which vblank is high.
REQ-029 SHALL register rd_cell with 1-cycle latency: rd_cell(t+1) = cell[rd_col][rd_row](t).
REQ-030 SHALL return 00 on rd_cell when rd_col >= COLS or rd_row >= ROWS.
REQ-031 On a same-cycle read and write to one cell, SHALL return the pre-write value (read-before-write).
REQ-032 SHALL hold mv_status and mv_row between completions.
REQ-033 SHALL compute board_full combinationally from the height counters.
REQ-034 SHALL ignore vblank dropping during WAIT_VBL (remain waiting); the commit cycle is the only vblank-sensitive cycle.

Reset
REQ-035 While rst_n is low, SHALL force state IDLE and clear all cells, all heights, mv_done, mv_status, mv_row and rd_cell to 0.
REQ-036 rst_n asserted during WAIT_VBL or CLEAR SHALL abort the operation, with no write and no mv_done.
REQ-037 SHALL hold mv_ready at 1 in the first cycle after rst_n deasserts.

Verification
REQ-038 Reset, then move col 3 / player 0 with vblank=1 -> mv_done pulses 4 cycles after acceptance; status 00, mv_row 0; rd (3,0) returns 01 one cycle later.
REQ-039 Seven yellow moves into col 2 -> first six give mv_row 0..5 with status 00; the seventh gives status 01, no write, and no vblank wait.
REQ-040 Move col 7 -> status 10 in DONE 2 cycles after acceptance; the board is unchanged.
REQ-041 Hold vblank=0 for 100 cycles after accepting a move -> no cell changes and mv_ready stays 0; raise vblank -> commit occurs, and the next cycle mv_done=1.
REQ-042 clr_req and mv_valid both high in IDLE -> clear wins; after vblank, every rd_cell reads 00, board_full=0, and mv_ready returns high.
REQ-043 Fill all 42 cells -> board_full=1; pulse rst_n low mid-WAIT_VBL -> all cells read 00, mv_done stays 0, board_full=0.
